// File: rtl/collision_pkg.sv
// Shared constants for the collision detector: wall bit positions in the
// hit vector and a counter-width helper.
package collision_pkg;

    localparam int WALL_LEFT   = 0;
    localparam int WALL_RIGHT  = 1;
    localparam int WALL_TOP    = 2;
    localparam int WALL_BOTTOM = 3;
    localparam int WALL_VEC_W  = 4;

    // Never returns zero, so a degenerate 1-pixel raster still gets a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_detector_raster_counter.sv
// Column/row position tracker driven by blanking levels and line/frame strobes.
// Both counters saturate at the last visible pixel/line.
module raster_counter
    import collision_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COL_W    = cnt_width(H_ACTIVE),
    parameter int ROW_W    = cnt_width(V_ACTIVE)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_N,
    input  logic             i_HBlank,
    input  logic             i_VBlank,
    input  logic             i_HReset,
    input  logic             i_VReset,
    output logic [COL_W-1:0] o_Col,
    output logic [ROW_W-1:0] o_Row
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_hblank_d;
    logic             w_hblank_rise;

    assign w_hblank_rise = i_HBlank & ~r_hblank_d;

    // Previous-HBlank resets high so blanking held across reset release
    // is not mistaken for a fresh line end.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hblank_d <= 1'b1;
        end else begin
            r_hblank_d <= i_HBlank;

            if (i_HReset) begin
                r_col <= '0;
            end else if (!i_HBlank && (r_col != COL_MAX)) begin
                r_col <= r_col + COL_W'(1);
            end

            if (i_VReset) begin
                r_row <= '0;
            end else if (w_hblank_rise && !i_VBlank && (r_row != ROW_MAX)) begin
                r_row <= r_row + ROW_W'(1);
            end
        end
    end

    assign o_Col = r_col;
    assign o_Row = r_row;

endmodule

// File: rtl/collision_detector.sv
// Per-frame ball/wall and ball/object collision detector with results committed on VReset.
// Optional interrupt output enabled by defining COLLISION_DETECTOR_IRQ_EN.
module collision_detector
    import collision_pkg::*;
#(
    parameter int N_OBJ    = 3,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WALL_W   = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_N,
    input  logic [N_OBJ-1:0]      i_Obj_Video,
    input  logic                  i_HBlank,
    input  logic                  i_VBlank,
    input  logic                  i_HReset,
    input  logic                  i_VReset,
    output logic [WALL_VEC_W-1:0] o_Wall_Hit,
    output logic [N_OBJ-2:0]      o_Obj_Hit,
    output logic                  o_Frame_Valid
`ifdef COLLISION_DETECTOR_IRQ_EN
    ,
    output logic                  o_Irq,
    input  logic                  i_Irq_Ack
`endif
);

    localparam int COL_W = cnt_width(H_ACTIVE);
    localparam int ROW_W = cnt_width(V_ACTIVE);

    localparam logic [COL_W-1:0] LEFT_LIM   = COL_W'(WALL_W);
    localparam logic [COL_W-1:0] RIGHT_LIM  = COL_W'(H_ACTIVE - WALL_W);
    localparam logic [ROW_W-1:0] TOP_LIM    = ROW_W'(WALL_W);
    localparam logic [ROW_W-1:0] BOTTOM_LIM = ROW_W'(V_ACTIVE - WALL_W);

    logic [COL_W-1:0]      w_col;
    logic [ROW_W-1:0]      w_row;
    logic                  w_sample;
    logic                  w_ball;
    logic [WALL_VEC_W-1:0] w_wall_set;
    logic [N_OBJ-2:0]      w_obj_set;

    logic [WALL_VEC_W-1:0] r_wall_acc;
    logic [N_OBJ-2:0]      r_obj_acc;
    logic [WALL_VEC_W-1:0] r_wall_hit;
    logic [N_OBJ-2:0]      r_obj_hit;
    logic                  r_frame_valid;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_raster (
        .i_Clk    (i_Clk),
        .i_Rst_N  (i_Rst_N),
        .i_HBlank (i_HBlank),
        .i_VBlank (i_VBlank),
        .i_HReset (i_HReset),
        .i_VReset (i_VReset),
        .o_Col    (w_col),
        .o_Row    (w_row)
    );

    // The VReset cycle is never sampled: it belongs to neither frame.
    assign w_sample = ~i_HBlank & ~i_VBlank & ~i_VReset;
    assign w_ball   = w_sample & i_Obj_Video[0];

    always_comb begin
        w_wall_set = '0;
        if (w_ball) begin
            w_wall_set[WALL_LEFT]   = (w_col <  LEFT_LIM);
            w_wall_set[WALL_RIGHT]  = (w_col >= RIGHT_LIM);
            w_wall_set[WALL_TOP]    = (w_row <  TOP_LIM);
            w_wall_set[WALL_BOTTOM] = (w_row >= BOTTOM_LIM);
        end
    end

    assign w_obj_set = {(N_OBJ-1){w_ball}} & i_Obj_Video[N_OBJ-1:1];

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_wall_acc    <= '0;
            r_obj_acc     <= '0;
            r_wall_hit    <= '0;
            r_obj_hit     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= i_VReset;
            if (i_VReset) begin
                r_wall_hit <= r_wall_acc;
                r_obj_hit  <= r_obj_acc;
                r_wall_acc <= '0;
                r_obj_acc  <= '0;
            end else begin
                r_wall_acc <= r_wall_acc | w_wall_set;
                r_obj_acc  <= r_obj_acc  | w_obj_set;
            end
        end
    end

    assign o_Wall_Hit    = r_wall_hit;
    assign o_Obj_Hit     = r_obj_hit;
    assign o_Frame_Valid = r_frame_valid;

`ifdef COLLISION_DETECTOR_IRQ_EN
    logic r_irq;

    // A commit carrying any hit takes priority over a coincident acknowledge.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_irq <= 1'b0;
        end else if (i_VReset && ((|r_wall_acc) || (|r_obj_acc))) begin
            r_irq <= 1'b1;
        end else if (i_Irq_Ack) begin
            r_irq <= 1'b0;
        end
    end

    assign o_Irq = r_irq;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Directed self-checking bench for collision_detector (default 640x480, 3 objects).
// Interrupt checks are included when COLLISION_DETECTOR_IRQ_EN is defined.
module tb_collision_detector;

    localparam int N_OBJ = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             hb    = 1'b1;
    logic             vb    = 1'b1;
    logic             hr    = 1'b0;
    logic             vr    = 1'b0;
    logic [N_OBJ-1:0] vid   = '0;
    logic [3:0]       wall;
    logic [N_OBJ-2:0] obj;
    logic             fv;
`ifdef COLLISION_DETECTOR_IRQ_EN
    logic             irq;
    logic             ack = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    collision_detector #(
        .N_OBJ    (N_OBJ),
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .WALL_W   (2)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_N       (rst_n),
        .i_Obj_Video   (vid),
        .i_HBlank      (hb),
        .i_VBlank      (vb),
        .i_HReset      (hr),
        .i_VReset      (vr),
        .o_Wall_Hit    (wall),
        .o_Obj_Hit     (obj),
        .o_Frame_Valid (fv)
`ifdef COLLISION_DETECTOR_IRQ_EN
        ,
        .o_Irq         (irq),
        .i_Irq_Ack     (ack)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic commit(input logic hb_at, input logic [N_OBJ-1:0] vid_at);
        hb  = hb_at;
        vid = vid_at;
        vr  = 1'b1;
        hr  = 1'b1;
        tick();
        vr  = 1'b0;
        hr  = 1'b0;
        hb  = 1'b1;
        vid = '0;
    endtask

    task automatic commit_check(input string tag, input logic [3:0] w, input logic [1:0] o);
        commit(1'b1, '0);
        check({tag, "_fv"},   32'(fv),   32'd1);
        check({tag, "_wall"}, 32'(wall), 32'(w));
        check({tag, "_obj"},  32'(obj),  32'(o));
        tick();
        check({tag, "_fv_low"}, 32'(fv),   32'd0);
        check({tag, "_hold"},   32'(wall), 32'(w));
    endtask

    // One line: HReset, n active pixels (ball pattern v only at ball_col), then blanking.
    task automatic line(input int n, input int ball_col, input logic [N_OBJ-1:0] v);
        hr = 1'b1;
        tick();
        hr = 1'b0;
        hb = 1'b0;
        for (int c = 0; c < n; c++) begin
            vid = (c == ball_col) ? v : '0;
            tick();
        end
        vid = '0;
        hb  = 1'b1;
        tick();
    endtask

    task automatic pixel_at(input int row, input int col, input logic [N_OBJ-1:0] v);
        for (int r = 0; r < row; r++) line(1, -1, '0);
        line(col + 1, col, v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        check("rst_wall", 32'(wall), 32'd0);
        check("rst_obj",  32'(obj),  32'd0);
        check("rst_fv",   32'(fv),   32'd0);
`ifdef COLLISION_DETECTOR_IRQ_EN
        check("rst_irq",  32'(irq),  32'd0);
`endif
        rst_n = 1'b1;
        vb    = 1'b0;
        tick();

        commit_check("empty0", 4'b0000, 2'b00);

        pixel_at(100, 0, 3'b001);
        commit_check("left", 4'b0001, 2'b00);

        pixel_at(479, 639, 3'b001);
        commit_check("bot_right", 4'b1010, 2'b00);

        pixel_at(240, 320, 3'b101);
        commit_check("obj2", 4'b0000, 2'b10);
        commit_check("empty_after_obj", 4'b0000, 2'b00);

        pixel_at(50, 320, 3'b110);
        commit_check("no_ball", 4'b0000, 2'b00);

        pixel_at(50, 320, 3'b011);
        commit_check("obj1", 4'b0000, 2'b01);

        pixel_at(0, 0, 3'b001);
        commit_check("corner_tl", 4'b0101, 2'b00);

        pixel_at(1, 1, 3'b001);
        commit_check("inner_edge_tl", 4'b0101, 2'b00);

        pixel_at(2, 2, 3'b001);
        commit_check("just_inside_tl", 4'b0000, 2'b00);

        pixel_at(478, 638, 3'b001);
        commit_check("inner_edge_br", 4'b1010, 2'b00);

        pixel_at(477, 637, 3'b001);
        commit_check("just_inside_br", 4'b0000, 2'b00);

        pixel_at(500, 320, 3'b001);
        commit_check("row_sat", 4'b1000, 2'b00);

        pixel_at(10, 700, 3'b001);
        commit_check("col_sat", 4'b0010, 2'b00);

        pixel_at(0, 0, 3'b001);
        pixel_at(5, 639, 3'b101);
        commit_check("sticky", 4'b0111, 2'b10);

        // Ball at col 0 row 0 but masked by HBlank, then by VBlank.
        vid = 3'b001;
        for (int i = 0; i < 3; i++) tick();
        vb = 1'b1;
        hb = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        hb  = 1'b1;
        vb  = 1'b0;
        vid = '0;
        tick();
        commit_check("gate_blank", 4'b0000, 2'b00);

        // Ball at col 0 row 0 during the VReset cycle itself.
        vr  = 1'b1;
        hb  = 1'b0;
        vid = 3'b101;
        tick();
        vr  = 1'b0;
        hb  = 1'b1;
        vid = '0;
        check("gate_vr_fv",   32'(fv),   32'd1);
        check("gate_vr_wall", 32'(wall), 32'd0);
        commit_check("gate_vr_next", 4'b0000, 2'b00);

        pixel_at(100, 0, 3'b001);
        commit_check("pre_rst", 4'b0001, 2'b00);
        pixel_at(100, 0, 3'b001);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wall", 32'(wall), 32'd0);
        check("async_rst_obj",  32'(obj),  32'd0);
        check("async_rst_fv",   32'(fv),   32'd0);
`ifdef COLLISION_DETECTOR_IRQ_EN
        check("async_rst_irq",  32'(irq),  32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        commit_check("rst_discard", 4'b0000, 2'b00);

        pixel_at(5, 0, 3'b001);
        commit_check("post_rst", 4'b0001, 2'b00);

`ifdef COLLISION_DETECTOR_IRQ_EN
        check("irq_set", 32'(irq), 32'd1);
        pixel_at(3, 0, 3'b001);
        ack = 1'b1;
        commit(1'b1, '0);
        ack = 1'b0;
        check("irq_set_beats_ack", 32'(irq),  32'd1);
        check("irq_commit_wall",   32'(wall), 32'd1);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("irq_lone_ack", 32'(irq), 32'd0);
        commit_check("irq_empty", 4'b0000, 2'b00);
        check("irq_empty_no_set", 32'(irq), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 The module SHALL have parameter N_OBJ, default 3, number of object video channels; channel 0 is the ball.
REQ-002 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 The module SHALL have parameter WALL_W, default 2, wall thickness in pixels/lines, range 1..H_ACTIVE/2.
REQ-005 The module SHALL have port i_Clk, input, 1, pixel clock.
REQ-006 The module SHALL have port i_Rst_N, input, 1, reset; one clock, asynchronous active-low reset.
REQ-007 The module SHALL have port i_Obj_Video, input, N_OBJ, per-object pixel-on flags.
REQ-008 The module SHALL have ports i_HBlank / i_VBlank, input, 1 each, blanking levels.
REQ-009 The module SHALL have ports i_HReset / i_VReset, input, 1 each, single-cycle line/frame start strobes.
REQ-010 The module SHALL have port o_Wall_Hit, output, 4, committed ball-wall hits {bottom, top, right, left}.
REQ-011 The module SHALL have port o_Obj_Hit, output, N_OBJ-1, committed ball-object overlaps, bit k-1 for object k.
REQ-012 The module SHALL have port o_Frame_Valid, output, 1, one-cycle pulse when new results are committed.

Function
REQ-013 Column counter SHALL clear on i_HReset and increment each cycle with i_HBlank low; width $clog2(H_ACTIVE); saturates at H_ACTIVE-1.
REQ-014 Row counter SHALL clear on i_VReset and increment on the i_HBlank rising edge while i_VBlank low; saturates at V_ACTIVE-1.
REQ-015 A pixel SHALL be sampled only when i_HBlank and i_VBlank are both low and i_VReset is low.
REQ-016 Sampled ball pixel SHALL set accumulator bits: left if col<WALL_W, right if col>=H_ACTIVE-WALL_W, top if row<WALL_W, bottom if row>=V_ACTIVE-WALL_W; multiple bits may set on one pixel (corners).
REQ-017 Sampled pixel with ball and object k both high SHALL set object accumulator bit k-1.
REQ-018 Accumulator bits SHALL be sticky for the remainder of the frame.
REQ-019 On i_VReset the accumulators SHALL transfer to o_Wall_Hit/o_Obj_Hit and clear in the same edge; outputs hold stable for the whole following frame.
REQ-020 o_Frame_Valid SHALL be high exactly in the cycle after i_VReset is sampled.
REQ-021 Latency SHALL be: hit pixel in frame F visible on outputs one cycle after the i_VReset ending frame F.
REQ-022 i_HReset and i_VReset high together SHALL clear both counters and commit once.
REQ-023 A frame with no hits SHALL commit all-zero outputs and still pulse o_Frame_Valid.

Reset
REQ-024 i_Rst_N low SHALL asynchronously clear counters, accumulators, o_Wall_Hit, o_Obj_Hit, o_Frame_Valid (and o_Irq when built).
REQ-025 After release, the first i_VReset SHALL commit only hits sampled after release; a reset mid-frame discards that partial frame.

Configuration
REQ-026 Macro COLLISION_DETECTOR_IRQ_EN defined SHALL add output o_Irq (1) and input i_Irq_Ack (1).
REQ-027 With the macro, o_Irq SHALL set on a commit with any nonzero result and clear on i_Irq_Ack; set wins over simultaneous ack.
REQ-028 Without the macro, those ports and their logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-029 Package collision_pkg SHALL hold wall index constants WALL_LEFT=0, WALL_RIGHT=1, WALL_TOP=2, WALL_BOTTOM=3 and the wall-vector width 4.
REQ-030 Sub-module raster_counter SHALL implement the column/row counters of REQ-013/014.

Verification
REQ-031 Ball on at col 0 row 100, i_VReset -> o_Wall_Hit=4'b0001 next cycle, o_Frame_Valid pulse.
REQ-032 Ball on at col 639 row 479 -> after commit o_Wall_Hit=4'b1010.
REQ-033 Ball and object 2 both on at col 320 row 240 -> o_Obj_Hit=2'b10, o_Wall_Hit=0; next empty frame commits all zeros.
REQ-034 Ball on during HBlank or on a cycle where i_VReset is high -> no bits set.
REQ-035 Hit at col 0, then i_Rst_N pulsed low before i_VReset -> outputs zero after commit.
REQ-036 With COLLISION_DETECTOR_IRQ_EN: hit frame commits -> o_Irq=1; i_Irq_Ack coincident with a new hit commit -> o_Irq stays 1; lone ack -> o_Irq=0.
